// File: rtl/hba_master.sv
// hba_master: HBA bus initiator that runs one host command per bus transaction,
// with arbitration, acknowledge wait and a request-to-ack timeout.
module hba_master #(
  parameter int DBUS_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rnw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DBUS_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DBUS_WIDTH-1:0] rsp_data,
  output logic                  rsp_timeout,
  output logic                  hba_mreq,
  input  logic                  hba_mgrant,
  output logic                  hba_select,
  output logic                  hba_rnw,
  output logic [ADDR_WIDTH-1:0] hba_abus_master,
  output logic [DBUS_WIDTH-1:0] hba_dbus_master,
  input  logic                  hba_xferack,
  input  logic [DBUS_WIDTH-1:0] hba_dbus
);
  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
  state_t                state_q, state_d;
  logic                  rnw_q, to_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DBUS_WIDTH-1:0] wdata_q, rdata_q;
  logic [15:0]           cnt_q;
  logic                  ack, expire;
  assign ack    = state_q == XFER && hba_xferack;
  assign expire = cnt_q + 16'd1 == 16'(TIMEOUT_CYCLES);
  // Counter idles at zero so it is already cleared when a command is accepted.
  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= state_q == IDLE ? '0 : cnt_q + 16'd1;
      if (cmd_valid && cmd_ready) begin
        rnw_q   <= cmd_rnw;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      if (state_d == DONE) begin
        rdata_q <= ack && rnw_q ? hba_dbus : '0;
        to_q    <= !ack;
      end
    end
  end
  // An ack arriving on the expiry cycle still completes the transfer.
  always_comb begin
    state_d = state_q == IDLE ? (cmd_valid ? REQ : IDLE) :
              state_q == REQ  ? (expire ? DONE : hba_mgrant ? XFER : REQ) :
              state_q == XFER ? (ack || expire ? DONE : XFER) : IDLE;
  end
  always_comb begin
    cmd_ready       = state_q == IDLE;
    hba_mreq        = state_q == REQ || state_q == XFER;
    hba_select      = state_q == XFER;
    hba_rnw         = hba_select && rnw_q;
    hba_abus_master = hba_select ? addr_q : '0;
    hba_dbus_master = hba_select && !rnw_q ? wdata_q : '0;
    rsp_valid       = state_q == DONE;
    rsp_data        = rdata_q;
    rsp_timeout     = to_q;
  end
endmodule

// File: tb/tb_hba_master.sv
// tb_hba_master: randomized scoreboard bench for hba_master with a reactive
// arbiter/slave and a latency/outcome reference model.
module tb_hba_master;
  localparam int DW = 8, AW = 12, T = 16;
  logic hba_clk = 0, hba_reset = 1, cmd_valid = 0, cmd_rnw = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_timeout, hba_mreq, hba_select, hba_rnw;
  logic [DW-1:0] rsp_data, hba_dbus_master;
  logic [AW-1:0] hba_abus_master;
  logic hba_mgrant = 0, hba_xferack = 0;
  logic [DW-1:0] hba_dbus = '0;
  typedef struct {
    logic rnw; logic [AW-1:0] addr; logic [DW-1:0] wdata, data; logic to; int lat; int acc;
  } exp_t;
  exp_t sb[$];
  exp_t m;
  int vecs = 0, errs = 0, cyc = 0, cur_g = 0, cur_k = 0, rc = 0, xc = 0;
  bit cur_ack = 1;
  logic [DW-1:0] slv_mem [4096];
  logic [DW-1:0] ref_mem [4096];
  logic [AW-1:0] pool [8];
  logic [DW-1:0] last_d = '0;
  logic last_t = 0;

  hba_master #(.DBUS_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .hba_clk(hba_clk), .hba_reset(hba_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .hba_mreq(hba_mreq), .hba_mgrant(hba_mgrant),
    .hba_select(hba_select), .hba_rnw(hba_rnw), .hba_abus_master(hba_abus_master),
    .hba_dbus_master(hba_dbus_master), .hba_xferack(hba_xferack), .hba_dbus(hba_dbus));

  always #5 hba_clk = ~hba_clk;
  always @(posedge hba_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Arbiter grants after cur_g waiting cycles; slave acks on XFER cycle cur_k+1.
  always @(negedge hba_clk) begin
    rc = hba_mreq && !hba_select ? rc + 1 : 0;
    xc = hba_select ? xc + 1 : 0;
    hba_mgrant = rc > 0 ? rc > cur_g : 1'($urandom);
    if (hba_select && cur_ack && xc == cur_k + 1) begin
      hba_xferack = 1'b1;
      hba_dbus = slv_mem[hba_abus_master];
      if (!hba_rnw) slv_mem[hba_abus_master] = hba_dbus_master;
    end else begin
      hba_xferack = hba_select ? 1'b0 : 1'($urandom);
      hba_dbus = DW'($urandom);
    end
  end

  always @(negedge hba_clk) begin
    if (hba_reset) begin
      last_d = '0;
      last_t = 1'b0;
    end else begin
      if (hba_select) begin
        if (sb.size() == 0) chk("select_without_cmd", 1, 0);
        else begin
          chk("abus", 32'(hba_abus_master), 32'(sb[0].addr));
          chk("rnw", 32'(hba_rnw), 32'(sb[0].rnw));
          chk("dbus_master", 32'(hba_dbus_master), 32'(sb[0].rnw ? 8'h00 : sb[0].wdata));
          chk("mreq_in_xfer", 32'(hba_mreq), 1);
        end
      end else chk("bus_quiet", 32'({hba_rnw, hba_abus_master, hba_dbus_master}), 0);
      if (cmd_ready) chk("idle_outputs", 32'({hba_mreq, rsp_valid}), 0);
      if (rsp_valid) begin
        if (sb.size() == 0) chk("spurious_rsp", 1, 0);
        else begin
          m = sb.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(m.data));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(m.to));
          chk("rsp_latency", 32'(cyc - m.acc), 32'(m.lat));
          chk("done_bus_quiet", 32'({hba_mreq, hba_select}), 0);
        end
        last_d = rsp_data;
        last_t = rsp_timeout;
      end else chk("rsp_hold", 32'({rsp_timeout, rsp_data}), 32'({last_t, last_d}));
    end
  end

  task automatic check_reset_state(input string nm);
    chk({nm, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({nm, "_outputs"}, 32'({hba_mreq, hba_select, hba_rnw, hba_abus_master, hba_dbus_master,
                               rsp_valid, rsp_data, rsp_timeout}), 0);
  endtask

  // Expected outcome: success iff ack exists and grant wait + ack wait fit in T cycles.
  task automatic issue(input logic rnw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input int g, input int k, input bit ack, input bit rst_mid);
    exp_t e;
    bit ok;
    int n;
    @(posedge hba_clk); #1;
    cur_g = g; cur_k = k; cur_ack = ack;
    cmd_valid = 1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wd;
    n = 0;
    do begin @(negedge hba_clk); n++; end while (!cmd_ready && n < 50);
    if (!cmd_ready) begin
      chk("accept_wait_expired", 0, 1);
      cmd_valid = 0;
      return;
    end
    ok = ack && g + k + 2 <= T;
    e.rnw = rnw; e.addr = addr; e.wdata = wd;
    e.data = ok && rnw ? ref_mem[addr] : '0;
    e.to = !ok;
    e.lat = ok ? g + k + 2 : T;
    e.acc = cyc + 1;
    if (ok && !rnw) ref_mem[addr] = wd;
    sb.push_back(e);
    @(posedge hba_clk); #1;
    cmd_valid = 0; cmd_rnw = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
    if (rst_mid) begin
      n = 0;
      do begin @(negedge hba_clk); n++; end while (!hba_select && n < 50);
      if (!hba_select) chk("select_wait_expired", 0, 1);
      @(posedge hba_clk); #1;
      hba_reset = 1;
      sb.delete();
      @(posedge hba_clk); #1;
      hba_reset = 0;
      @(negedge hba_clk);
      check_reset_state("mid_reset");
      return;
    end
    n = 0;
    while (sb.size() > 0 && n < 100) begin @(negedge hba_clk); n++; end
    if (sb.size() > 0) begin
      chk("rsp_wait_expired", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      slv_mem[i] = DW'($urandom);
      ref_mem[i] = slv_mem[i];
    end
    for (int i = 0; i < 8; i++) pool[i] = {4'($urandom_range(0, 6)), 8'($urandom)};
    repeat (3) @(posedge hba_clk);
    #1 hba_reset = 0;
    @(negedge hba_clk);
    check_reset_state("reset");
    issue(0, 12'h201, 8'hA5, 0, 2, 1, 0);
    issue(1, 12'h201, 8'h00, 0, 2, 1, 0);
    issue(1, 12'h201, 8'h00, 10, 0, 1, 0);
    issue(1, 12'h705, 8'h00, 0, 0, 0, 0);
    issue(0, 12'h703, 8'h77, 2, 0, 0, 0);
    issue(1, 12'h201, 8'h00, 3, 11, 1, 0);
    issue(1, 12'h201, 8'h00, 3, 12, 1, 0);
    issue(1, 12'h201, 8'h00, 14, 0, 1, 0);
    issue(1, 12'h201, 8'h00, 15, 0, 1, 0);
    issue(0, 12'h202, 8'h3C, 0, 0, 0, 1);
    issue(0, 12'h202, 8'h5A, 0, 1, 1, 0);
    issue(1, 12'h202, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 150; i++)
      issue(1'($urandom), pool[$urandom_range(0, 7)], DW'($urandom), $urandom_range(0, 10),
            $urandom_range(0, 8), $urandom_range(0, 9) != 0, 0);
    repeat (3) @(negedge hba_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
